// File: rtl/bit_count_seq.sv
// -----------------------------------------------------------------------------
// bit_count_seq
//
// Sequential bit counter. Scans the vector {i_argA, i_argB} CHUNK bits per
// clock and produces one of four counts: ones, zeros, leading zeros (from the
// MSB of i_argA) or trailing zeros (from the LSB of i_argB). The result is
// wide enough to hold 0..LEN, so it never wraps.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       synchronous reset, active-high, highest priority
//   i_start     request, sampled only while o_busy is low
//   i_mode      00 ones, 01 zeros, 10 leading zeros, 11 trailing zeros
//   i_argA      upper half of the scanned vector (sign is irrelevant)
//   i_argB      lower half of the scanned vector
//   o_result    count, held until the next result is produced
//   o_valid     one-cycle pulse when o_result is updated
//   o_busy      high while scanning
//   o_overflow  count exceeds what a BITS-wide legacy result could hold
// -----------------------------------------------------------------------------
module bit_count_seq #(
  parameter int BITS  = 8,
  parameter int LEN   = 2 * BITS,
  parameter int CHUNK = 2,
  parameter int OUT_W = $clog2(LEN + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [BITS-1:0]  i_argA,
  input  logic [BITS-1:0]  i_argB,
  output logic [OUT_W-1:0] o_result,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_overflow
);

  localparam int          NCHUNK     = LEN / CHUNK;
  localparam int          CNT_W      = $clog2(NCHUNK + 1);
  localparam int unsigned LEGACY_MAX = (2 ** BITS) - 1;

  if (CHUNK < 1 || (LEN % CHUNK) != 0) begin : g_bad_chunk
    $error("bit_count_seq: CHUNK must be >= 1 and divide LEN");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_ONES  = 2'b00,
    MODE_ZEROS = 2'b01,
    MODE_LZ    = 2'b10,
    MODE_TZ    = 2'b11
  } mode_e;

  state_e            state_q, state_n;
  mode_e             mode_q,  mode_n;
  logic [LEN-1:0]    vec_q,   vec_n;
  logic [OUT_W-1:0]  acc_q,   acc_n;
  logic              stop_q,  stop_n;
  logic [CNT_W-1:0]  cnt_q,   cnt_n;
  logic [OUT_W-1:0]  res_q,   res_n;
  logic              ovf_q,   ovf_n;

  // Per-chunk datapath: what the accumulator, stop flag and vector become
  // after consuming the chunk currently at the scan end of vec_q.
  logic [CHUNK-1:0]  chunk;
  logic [OUT_W-1:0]  acc_step;
  logic              stop_step;
  logic [LEN-1:0]    vec_shift;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    chunk     = (mode_q == MODE_LZ) ? vec_q[LEN-1 -: CHUNK] : vec_q[CHUNK-1:0];
    vec_shift = (mode_q == MODE_LZ) ? (vec_q << CHUNK) : (vec_q >> CHUNK);
    acc_step  = acc_q;
    stop_step = stop_q;
    for (int i = 0; i < CHUNK; i++) begin
      case (mode_q)
        MODE_ONES: begin
          if (chunk[i]) acc_step = acc_step + OUT_W'(1);
        end
        MODE_ZEROS: begin
          if (!chunk[i]) acc_step = acc_step + OUT_W'(1);
        end
        MODE_LZ: begin
          // Leading zeros walk the chunk MSB first.
          if (!stop_step) begin
            if (chunk[CHUNK-1-i]) stop_step = 1'b1;
            else                  acc_step  = acc_step + OUT_W'(1);
          end
        end
        default: begin
          // Trailing zeros walk the chunk LSB first.
          if (!stop_step) begin
            if (chunk[i]) stop_step = 1'b1;
            else          acc_step  = acc_step + OUT_W'(1);
          end
        end
      endcase
    end
  end

  // Next-state and register-load logic.
  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    vec_n   = vec_q;
    acc_n   = acc_q;
    stop_n  = stop_q;
    cnt_n   = cnt_q;
    res_n   = res_q;
    ovf_n   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_n = IDLE;
        if (i_start) begin
          state_n = RUN;
          mode_n  = mode_e'(i_mode);
          vec_n   = {i_argA, i_argB};
          acc_n   = '0;
          stop_n  = 1'b0;
          cnt_n   = CNT_W'(NCHUNK);
        end
      end
      RUN: begin
        vec_n  = vec_shift;
        acc_n  = acc_step;
        stop_n = stop_step;
        cnt_n  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Last chunk: publish the final count as we enter DONE.
          state_n = DONE;
          res_n   = acc_step;
          ovf_n   = 32'(acc_step) > LEGACY_MAX;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_ONES;
      vec_q   <= '0;
      acc_q   <= '0;
      stop_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      mode_q  <= mode_n;
      vec_q   <= vec_n;
      acc_q   <= acc_n;
      stop_q  <= stop_n;
      cnt_q   <= cnt_n;
      res_q   <= res_n;
      ovf_q   <= ovf_n;
    end
  end

  assign o_busy     = (state_q == RUN);
  assign o_valid    = (state_q == DONE);
  assign o_result   = res_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_bit_count_seq.sv
// -----------------------------------------------------------------------------
// tb_bit_count_seq
//
// Two instances: u_a (BITS=4, CHUNK=2) and u_b (BITS=2, CHUNK=1), both with
// LEN/CHUNK = 4 scan cycles. Directed vectors with hand-computed counts are
// applied from a table; handshake and mid-scan reset are hand-written.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bit_count_seq;

  localparam int TIMEOUT  = 30;
  localparam int SCAN     = 4;        // LEN/CHUNK for both instances
  localparam int LATENCY  = SCAN + 1; // start cycle to o_valid cycle

  logic       clk;
  logic       rst;

  logic       start_a, start_b;
  logic [1:0] mode_a,  mode_b;
  logic [3:0] arga_a,  argb_a;
  logic [1:0] arga_b,  argb_b;
  logic [3:0] result_a;
  logic [2:0] result_b;
  logic       valid_a, busy_a, ovf_a;
  logic       valid_b, busy_b, ovf_b;

  int n_cmp  = 0;
  int n_fail = 0;

  bit_count_seq #(.BITS(4), .CHUNK(2)) u_a (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start_a),
    .i_mode     (mode_a),
    .i_argA     (arga_a),
    .i_argB     (argb_a),
    .o_result   (result_a),
    .o_valid    (valid_a),
    .o_busy     (busy_a),
    .o_overflow (ovf_a)
  );

  bit_count_seq #(.BITS(2), .CHUNK(1)) u_b (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start_b),
    .i_mode     (mode_b),
    .i_argA     (arga_b),
    .i_argB     (argb_b),
    .o_result   (result_b),
    .o_valid    (valid_b),
    .o_busy     (busy_b),
    .o_overflow (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         dut;
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    int         res;
    int         ovf;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive(input int dut, input logic st, input logic [1:0] m,
                       input logic [3:0] a, input logic [3:0] b);
    if (dut == 0) begin
      start_a = st; mode_a = m; arga_a = a; argb_a = b;
    end else begin
      start_b = st; mode_b = m; arga_b = a[1:0]; argb_b = b[1:0];
    end
  endtask

  function automatic int get_res(input int dut);
    return (dut == 0) ? int'(result_a) : int'(result_b);
  endfunction

  function automatic int get_valid(input int dut);
    return (dut == 0) ? int'(valid_a) : int'(valid_b);
  endfunction

  function automatic int get_busy(input int dut);
    return (dut == 0) ? int'(busy_a) : int'(busy_b);
  endfunction

  function automatic int get_ovf(input int dut);
    return (dut == 0) ? int'(ovf_a) : int'(ovf_b);
  endfunction

  // Called on the falling edge; counts falling edges (current one = 1) until
  // o_valid is seen, bounded by TIMEOUT.
  task automatic wait_valid(input int dut, input string name,
                            output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = 0;
    while (get_valid(dut) == 0 && lat <= TIMEOUT) begin
      if (get_busy(dut) != 0) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({name, "_valid_seen"}, get_valid(dut), 1);
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    int busy_cnt;
    drive(v.dut, 1'b1, v.mode, v.a, v.b);
    @(negedge clk);
    drive(v.dut, 1'b0, v.mode, v.a, v.b);
    wait_valid(v.dut, v.name, lat, busy_cnt);
    check({v.name, "_latency"},  lat + 1, LATENCY + 1);
    check({v.name, "_busy_cyc"}, busy_cnt, SCAN);
    check({v.name, "_result"},   get_res(v.dut), v.res);
    check({v.name, "_overflow"}, get_ovf(v.dut), v.ovf);
    @(negedge clk);
    check({v.name, "_valid_drop"}, get_valid(v.dut), 0);
    check({v.name, "_held"},       get_res(v.dut), v.res);
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int valid_seen;

    // dut, mode, A, B, expected result, expected overflow, name
    vecs.push_back('{0, 2'b00, 4'b1011, 4'b0110, 5, 0, "a_ones"});
    vecs.push_back('{0, 2'b01, 4'b1011, 4'b0110, 3, 0, "a_zeros"});
    vecs.push_back('{0, 2'b10, 4'b0000, 4'b0010, 6, 0, "a_lz"});
    vecs.push_back('{0, 2'b11, 4'b0000, 4'b0010, 1, 0, "a_tz"});
    vecs.push_back('{0, 2'b10, 4'b0000, 4'b0000, 8, 0, "a_lz_allzero"});
    vecs.push_back('{0, 2'b11, 4'b0000, 4'b0000, 8, 0, "a_tz_allzero"});
    vecs.push_back('{0, 2'b00, 4'hF,    4'hF,    8, 0, "a_ones_allone"});
    vecs.push_back('{0, 2'b01, 4'hF,    4'hF,    0, 0, "a_zeros_allone"});
    vecs.push_back('{0, 2'b10, 4'hF,    4'hF,    0, 0, "a_lz_allone"});
    vecs.push_back('{0, 2'b11, 4'hF,    4'hF,    0, 0, "a_tz_allone"});
    vecs.push_back('{0, 2'b10, 4'b0100, 4'b0000, 1, 0, "a_lz_midchunk"});
    vecs.push_back('{0, 2'b10, 4'b0010, 4'b0000, 2, 0, "a_lz_stop"});
    vecs.push_back('{0, 2'b11, 4'b0000, 4'b0100, 2, 0, "a_tz_midchunk"});
    vecs.push_back('{0, 2'b11, 4'b1000, 4'b0000, 7, 0, "a_tz_long"});
    vecs.push_back('{1, 2'b00, 4'b0011, 4'b0011, 4, 1, "b_ones_ovf"});
    vecs.push_back('{1, 2'b00, 4'b0001, 4'b0010, 2, 0, "b_ones"});
    vecs.push_back('{1, 2'b11, 4'b0000, 4'b0000, 4, 1, "b_tz_allzero"});
    vecs.push_back('{1, 2'b10, 4'b0001, 4'b0000, 1, 0, "b_lz"});

    rst = 1'b1;
    drive(0, 1'b0, 2'b00, 4'h0, 4'h0);
    drive(1, 1'b0, 2'b00, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    check("rst_result_a", int'(result_a), 0);
    check("rst_valid_a",  int'(valid_a),  0);
    check("rst_busy_a",   int'(busy_a),   0);
    check("rst_ovf_a",    int'(ovf_a),    0);
    check("rst_result_b", int'(result_b), 0);
    check("rst_busy_b",   int'(busy_b),   0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i]);

    // Start held during RUN with different operands must be ignored.
    drive(0, 1'b1, 2'b00, 4'b1011, 4'b0110);
    @(negedge clk);
    drive(0, 1'b1, 2'b01, 4'hF, 4'hF);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b0, 2'b01, 4'hF, 4'hF);
    wait_valid(0, "hs_first", lat, busy_cnt);
    check("hs_first_latency", lat, 3);
    check("hs_first_result",  int'(result_a), 5);

    // Start in the DONE cycle is accepted; next valid LEN/CHUNK+1 later.
    drive(0, 1'b1, 2'b11, 4'b0000, 4'b0010);
    @(negedge clk);
    drive(0, 1'b0, 2'b11, 4'b0000, 4'b0010);
    check("hs_b2b_busy",  int'(busy_a),  1);
    check("hs_b2b_valid", int'(valid_a), 0);
    wait_valid(0, "hs_second", lat, busy_cnt);
    check("hs_second_latency", lat, LATENCY);
    check("hs_second_result",  int'(result_a), 1);

    // Reset on the second RUN cycle aborts the scan.
    drive(0, 1'b1, 2'b00, 4'hF, 4'hF);
    @(negedge clk);
    drive(0, 1'b0, 2'b00, 4'hF, 4'hF);
    check("rs_busy_run1", int'(busy_a), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rs_busy",   int'(busy_a),   0);
    check("rs_result", int'(result_a), 0);
    check("rs_valid",  int'(valid_a),  0);
    check("rs_ovf",    int'(ovf_a),    0);
    valid_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid_a) valid_seen++;
    end
    check("rs_no_valid", valid_seen, 0);
    run_op('{0, 2'b00, 4'b1011, 4'b0110, 5, 0, "rs_fresh"});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
